// File: rtl/serial_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1/8N2 shifter, one clk115 cycle per bit.
// Define SERIAL_TX_FIFO_PARITY_EN to insert an even-parity bit between the data and stop bits.
module serial_tx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk115,
   input  logic                  reset,
   input  logic [7:0]            wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  busy,
   output logic                  tx,
   output logic                  end_of_send
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef SERIAL_TX_FIFO_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic parity_bit;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t state;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count_next;
   logic [7:0]            shift_reg;
   logic [2:0]            bit_cnt;
   logic                  stop_cnt;
   logic                  push;
   logic                  pop;
   logic                  last_stop;

   // A byte leaves the FIFO exactly when a START begins: from IDLE or straight out of the last stop bit.
   assign last_stop = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
   assign pop       = ((state == IDLE) || last_stop) && (count != '0);
   assign push      = wr_en && !full;
   assign busy      = (state != IDLE) || (count != '0);

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk115) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk115) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == (DEPTH_LOG2 + 1)'(DEPTH));
         // A write against a full FIFO is lost even if a pop frees a slot on the same edge.
         if (wr_en && full)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk115) begin
      if (reset) begin
         state       <= IDLE;
         tx          <= 1'b1;
         end_of_send <= 1'b0;
         shift_reg   <= '0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
`ifdef SERIAL_TX_FIFO_PARITY_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         end_of_send <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
            end
            START: begin
               state     <= DATA;
               tx        <= shift_reg[0];
               shift_reg <= {1'b0, shift_reg[7:1]};
               bit_cnt   <= '0;
            end
            DATA: begin
               if (bit_cnt == 3'd7) begin
`ifdef SERIAL_TX_FIFO_PARITY_EN
                  state <= PARITY;
                  tx    <= parity_bit;
`else
                  state       <= STOP;
                  tx          <= 1'b1;
                  stop_cnt    <= 1'b0;
                  end_of_send <= (STOP_BITS == 1);
`endif
               end else begin
                  tx        <= shift_reg[0];
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
            end
`ifdef SERIAL_TX_FIFO_PARITY_EN
            PARITY: begin
               state       <= STOP;
               tx          <= 1'b1;
               stop_cnt    <= 1'b0;
               end_of_send <= (STOP_BITS == 1);
            end
`endif
            STOP: begin
               tx <= 1'b1;
               if (last_stop) begin
                  state <= IDLE;
               end else begin
                  stop_cnt    <= 1'b1;
                  end_of_send <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
         // Loading the next byte overrides the IDLE/STOP defaults so frames run back to back.
         if (pop) begin
            state     <= START;
            tx        <= 1'b0;
            shift_reg <= mem[rd_ptr];
`ifdef SERIAL_TX_FIFO_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
         end
      end
   end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Directed bench for serial_tx_fifo: one instance with a single stop bit, one with two.
// Expected line levels come from a vector table plus hand-written burst, overflow and reset sequences.
module tb_serial_tx_fifo;

`ifdef SERIAL_TX_FIFO_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk115;
   logic       reset;
   logic [7:0] wr_data1, wr_data2;
   logic       wr_en1, wr_en2;
   logic       full1, full2;
   logic [4:0] count1, count2;
   logic       overflow1, overflow2;
   logic       busy1, busy2;
   logic       tx1, tx2;
   logic       eos1, eos2;
   logic       use2;
   logic       cur_tx, cur_eos, cur_busy;
   logic [4:0] cur_count;

   int vectors;
   int miscompares;

   typedef struct {
      logic [7:0] data;
      logic       parity;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] exp_bytes[18];

   serial_tx_fifo #(.DEPTH_LOG2(4), .STOP_BITS(1)) dut (
      .clk115(clk115), .reset(reset), .wr_data(wr_data1), .wr_en(wr_en1),
      .full(full1), .count(count1), .overflow(overflow1), .busy(busy1),
      .tx(tx1), .end_of_send(eos1));

   serial_tx_fifo #(.DEPTH_LOG2(4), .STOP_BITS(2)) dut2 (
      .clk115(clk115), .reset(reset), .wr_data(wr_data2), .wr_en(wr_en2),
      .full(full2), .count(count2), .overflow(overflow2), .busy(busy2),
      .tx(tx2), .end_of_send(eos2));

   assign cur_tx    = use2 ? tx2 : tx1;
   assign cur_eos   = use2 ? eos2 : eos1;
   assign cur_busy  = use2 ? busy2 : busy1;
   assign cur_count = use2 ? count2 : count1;

   initial clk115 = 1'b0;
   always #5 clk115 = ~clk115;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      @(negedge clk115);
      reset = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [7:0] b);
      if (use2) begin
         wr_data2 = b;
         wr_en2   = 1'b1;
      end else begin
         wr_data1 = b;
         wr_en1   = 1'b1;
      end
      @(negedge clk115);
      wr_en1 = 1'b0;
      wr_en2 = 1'b0;
   endtask

   // Called at the negedge of the START cycle; returns at the negedge after the final stop bit.
   task automatic check_frame(input logic [7:0] b, input logic par, input int nstop);
      int   flen;
      logic e;
      flen = 1 + 8 + PAR + nstop;
      for (int k = 0; k < flen; k++) begin
         if (k == 0)
            e = 1'b0;
         else if (k <= 8)
            e = b[k-1];
         else if (PAR == 1 && k == 9)
            e = par;
         else
            e = 1'b1;
         check_output($sformatf("frame %02h cycle %0d tx", b, k), 32'(cur_tx), 32'(e));
         check_output($sformatf("frame %02h cycle %0d end_of_send", b, k), 32'(cur_eos), 32'(k == flen - 1));
         @(negedge clk115);
      end
   endtask

   task automatic run_single(input vec_t v, input int nstop);
      reset_pulse();
      apply_stimulus(v.data);
      check_output($sformatf("%02h queued count", v.data), 32'(cur_count), 32'd1);
      check_output($sformatf("%02h line idle before start", v.data), 32'(cur_tx), 32'd1);
      @(negedge clk115);
      check_frame(v.data, v.parity, nstop);
      check_output($sformatf("%02h busy after frame", v.data), 32'(cur_busy), 32'd0);
      check_output($sformatf("%02h line idle after frame", v.data), 32'(cur_tx), 32'd1);
   endtask

   initial begin
      string s;
      int    t;
      vectors     = 0;
      miscompares = 0;
      use2        = 1'b0;
      reset       = 1'b1;
      wr_en1      = 1'b0;
      wr_en2      = 1'b0;
      wr_data1    = 8'h00;
      wr_data2    = 8'h00;

      vecs[0] = '{8'h55, 1'b0};
      vecs[1] = '{8'h0F, 1'b0};
      vecs[2] = '{8'h07, 1'b1};
      vecs[3] = '{8'h03, 1'b0};
      vecs[4] = '{8'h80, 1'b1};
      vecs[5] = '{8'hFF, 1'b0};

      repeat (3) @(negedge clk115);
      check_output("reset tx", 32'(tx1), 32'd1);
      check_output("reset full", 32'(full1), 32'd0);
      check_output("reset count", 32'(count1), 32'd0);
      check_output("reset overflow", 32'(overflow1), 32'd0);
      check_output("reset busy", 32'(busy1), 32'd0);
      check_output("reset end_of_send", 32'(eos1), 32'd0);
      check_output("reset tx (2 stop)", 32'(tx2), 32'd1);
      check_output("reset count (2 stop)", 32'(count2), 32'd0);
      check_output("reset busy (2 stop)", 32'(busy2), 32'd0);
      reset = 1'b0;
      @(negedge clk115);

      for (int i = 0; i < 6; i++)
         run_single(vecs[i], 1);

      use2 = 1'b1;
      run_single('{8'h00, 1'b0}, 2);
      run_single(vecs[0], 2);
      use2 = 1'b0;

      // Burst: the first byte pops one cycle after it lands, so 18 writes are needed to fill 16 slots.
      s = "Hello, World!\n\r*";
      for (int i = 0; i < 16; i++)
         exp_bytes[i] = s[i];
      exp_bytes[16] = 8'h23;
      exp_bytes[17] = 8'h24;
      reset_pulse();
      fork
         begin
            for (int i = 0; i < 18; i++) begin
               wr_data1 = exp_bytes[i];
               wr_en1   = 1'b1;
               @(negedge clk115);
            end
            wr_en1 = 1'b0;
            check_output("burst full", 32'(full1), 32'd1);
            check_output("burst count", 32'(count1), 32'd16);
            check_output("burst no overflow yet", 32'(overflow1), 32'd0);
            for (int w = 0; w < 20 && eos1 !== 1'b1; w++)
               @(negedge clk115);
            check_output("pop cycle reached", 32'(eos1), 32'd1);
            wr_data1 = 8'hAA;
            wr_en1   = 1'b1;
            @(negedge clk115);
            wr_en1 = 1'b0;
            check_output("overflow set", 32'(overflow1), 32'd1);
            check_output("count after dropped write", 32'(count1), 32'd15);
            check_output("full cleared by pop", 32'(full1), 32'd0);
         end
         begin
            for (int w = 0; w < 6 && tx1 !== 1'b0; w++)
               @(negedge clk115);
            for (int j = 0; j < 18; j++)
               check_frame(exp_bytes[j], ^exp_bytes[j], 1);
         end
      join
      check_output("burst drained busy", 32'(busy1), 32'd0);
      check_output("burst drained count", 32'(count1), 32'd0);
      check_output("overflow sticky", 32'(overflow1), 32'd1);

      // Reset lands during data bit 3 of 0x0F with four more bytes waiting.
      reset_pulse();
      check_output("overflow cleared by reset", 32'(overflow1), 32'd0);
      wr_data1 = 8'h0F; wr_en1 = 1'b1; @(negedge clk115);
      for (int i = 1; i <= 4; i++) begin
         wr_data1 = 8'(i);
         @(negedge clk115);
      end
      wr_en1 = 1'b0;
      @(negedge clk115);
      check_output("abort: data bit 3 level", 32'(tx1), 32'd1);
      check_output("abort: queued count", 32'(count1), 32'd4);
      check_output("abort: busy before reset", 32'(busy1), 32'd1);
      reset = 1'b1;
      @(negedge clk115);
      reset = 1'b0;
      check_output("abort: tx after reset", 32'(tx1), 32'd1);
      check_output("abort: count after reset", 32'(count1), 32'd0);
      check_output("abort: end_of_send after reset", 32'(eos1), 32'd0);
      check_output("abort: busy after reset", 32'(busy1), 32'd0);
      t = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk115);
         if (tx1 !== 1'b1 || eos1 !== 1'b0)
            t++;
      end
      check_output("abort: line stays idle", 32'(t), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
